// File: rtl/matmul_engine.sv
// NxN output-stationary systolic matrix multiplier computing C = A x B.
// Operands are loaded element by element; results are read back one byte lane at a time.
module matmul_engine #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 16,
  localparam int LA   = $clog2(N * N),
  localparam int RB   = (ACC_W / 8 > 1) ? $clog2(ACC_W / 8) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          load_mat,
  input  logic [LA-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [LA-1:0] rd_addr,
  input  logic [RB-1:0] rd_byte,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done
);
  localparam int NN    = N * N;
  localparam int STEPS = 3 * N - 1;
  localparam int SW    = $clog2(3 * N);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          step_q, step_d;
  logic                   mode_q, mode_d;
  logic [DW-1:0]          a_mat_q [NN];
  logic [DW-1:0]          a_mat_d [NN];
  logic [DW-1:0]          b_mat_q [NN];
  logic [DW-1:0]          b_mat_d [NN];
  logic [DW-1:0]          pe_a_q  [NN];
  logic [DW-1:0]          pe_a_d  [NN];
  logic [DW-1:0]          pe_b_q  [NN];
  logic [DW-1:0]          pe_b_d  [NN];
  logic [ACC_W-1:0]       acc_q   [NN];
  logic [ACC_W-1:0]       acc_d   [NN];
  logic [DW-1:0]          inj_a   [N];
  logic [DW-1:0]          inj_b   [N];
  logic [DW-1:0]          a_in    [NN];
  logic [DW-1:0]          b_in    [NN];
  logic signed [DW:0]     op_a, op_b;
  logic signed [2*DW+1:0] prod;
  logic                   load_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      mode_q  <= 1'b0;
      a_mat_q <= '{default: '0};
      b_mat_q <= '{default: '0};
      pe_a_q  <= '{default: '0};
      pe_b_q  <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      a_mat_q <= a_mat_d;
      b_mat_q <= b_mat_d;
      pe_a_q  <= pe_a_d;
      pe_b_q  <= pe_b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mode_d  = mode_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        busy    = 1'b1;
        mode_d  = signed_mode;
        step_d  = '0;
        state_d = FEED;
      end
      FEED: begin
        busy = 1'b1;
        if (step_q == SW'(STEPS - 1)) state_d = DONE;
        else                          step_d  = step_q + 1'b1;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_mat_d = a_mat_q;
    b_mat_d = b_mat_q;
    pe_a_d  = pe_a_q;
    pe_b_d  = pe_b_q;
    acc_d   = acc_q;
    inj_a   = '{default: '0};
    inj_b   = '{default: '0};
    a_in    = '{default: '0};
    b_in    = '{default: '0};
    op_a    = '0;
    op_b    = '0;
    prod    = '0;
    load_ok = load_en && (state_q == IDLE || state_q == DONE) && (int'(load_addr) < NN);
    if (load_ok) begin
      if (load_mat) b_mat_d[load_addr] = load_data;
      else          a_mat_d[load_addr] = load_data;
    end
    // Skewed wavefront: row i / column i start i steps late; the final step drains zeros.
    if (state_q == FEED) begin
      for (int i = 0; i < N; i++) begin
        if (int'(step_q) >= i && int'(step_q) - i < N) begin
          inj_a[i] = a_mat_q[i * N + int'(step_q) - i];
          inj_b[i] = b_mat_q[(int'(step_q) - i) * N + i];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      a_in[i * N] = inj_a[i];
      b_in[i]     = inj_b[i];
      for (int j = 1; j < N; j++) begin
        a_in[i * N + j] = pe_a_q[i * N + j - 1];
        b_in[j * N + i] = pe_b_q[(j - 1) * N + i];
      end
    end
    case (state_q)
      CLEAR: begin
        pe_a_d = '{default: '0};
        pe_b_d = '{default: '0};
        acc_d  = '{default: '0};
      end
      FEED: begin
        for (int p = 0; p < NN; p++) begin
          pe_a_d[p] = a_in[p];
          pe_b_d[p] = b_in[p];
          // One extra top bit lets a single signed multiplier serve both modes.
          op_a     = {mode_q & pe_a_q[p][DW-1], pe_a_q[p]};
          op_b     = {mode_q & pe_b_q[p][DW-1], pe_b_q[p]};
          prod     = op_a * op_b;
          acc_d[p] = acc_q[p] + ACC_W'(prod);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < NN) rd_data = 8'(acc_q[rd_addr] >> (8 * rd_byte));
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Randomized scoreboard bench for matmul_engine: runs N=2 and N=3 instances against a
// plain-arithmetic matrix product model.
module tb_matmul_engine;
  typedef struct {
    int                kind;
    int                n;
    int                issue;
    logic [15:0][15:0] c;
  } exp_t;

  logic       clk         = 1'b0;
  logic       rst         = 1'b1;
  logic       load_en     = 1'b0;
  logic       load_mat    = 1'b0;
  logic [3:0] load_addr   = '0;
  logic [7:0] load_data   = '0;
  logic       start       = 1'b0;
  logic       signed_mode = 1'b0;
  logic [3:0] rd_addr     = '0;
  logic       rd_byte     = 1'b0;
  logic [7:0] rd_data2, rd_data3, rd_data_sel;
  logic       busy2, done2, busy3, done3, busy_sel, done_sel;

  int         cur_n = 2;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  logic [7:0] ma[16];
  logic [7:0] mb[16];
  bit         model_busy = 1'b0;

  matmul_engine #(.N(2), .DW(8), .ACC_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .load_en(load_en && cur_n == 2), .load_mat(load_mat),
    .load_addr(load_addr[1:0]), .load_data(load_data), .start(start && cur_n == 2),
    .signed_mode(signed_mode), .rd_addr(rd_addr[1:0]), .rd_byte(rd_byte),
    .rd_data(rd_data2), .busy(busy2), .done(done2)
  );

  matmul_engine #(.N(3), .DW(8), .ACC_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .load_en(load_en && cur_n == 3), .load_mat(load_mat),
    .load_addr(load_addr), .load_data(load_data), .start(start && cur_n == 3),
    .signed_mode(signed_mode), .rd_addr(rd_addr), .rd_byte(rd_byte),
    .rd_data(rd_data3), .busy(busy3), .done(done3)
  );

  assign rd_data_sel = (cur_n == 3) ? rd_data3 : rd_data2;
  assign busy_sel    = (cur_n == 3) ? busy3 : busy2;
  assign done_sel    = (cur_n == 3) ? done3 : done2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j], truncated to 16 bits.
  function automatic logic [15:0][15:0] modelC(input int n, input bit sm);
    logic [15:0][15:0] c;
    int s, x, y;
    c = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          x = sm ? int'($signed(ma[i * n + k])) : int'(ma[i * n + k]);
          y = sm ? int'($signed(mb[k * n + j])) : int'(mb[k * n + j]);
          s += x * y;
        end
        c[i * n + j] = 16'(s);
      end
    end
    return c;
  endfunction

  function automatic void modelWrite(input bit mat, input int addr, input logic [7:0] val);
    if (!model_busy && addr < cur_n * cur_n) begin
      if (mat) mb[addr] = val;
      else     ma[addr] = val;
    end
  endfunction

  task automatic loadElem(input bit mat, input int addr, input logic [7:0] val);
    @(negedge clk);
    load_en   = 1'b1;
    load_mat  = mat;
    load_addr = 4'(addr);
    load_data = val;
    modelWrite(mat, addr, val);
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic applyStimulus(input bit expect_it, input bit with_load, input bit mat,
                               input int addr, input logic [7:0] val);
    exp_t e;
    @(negedge clk);
    if (with_load) begin
      load_en   = 1'b1;
      load_mat  = mat;
      load_addr = 4'(addr);
      load_data = val;
      modelWrite(mat, addr, val);
    end
    start = 1'b1;
    if (expect_it) begin
      e.kind  = 0;
      e.n     = cur_n;
      e.issue = cyc;
      e.c     = modelC(cur_n, signed_mode);
      sb.push_back(e);
    end
    model_busy = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    load_en = 1'b0;
    checkOutput("busy_after_start", int'(busy_sel), 1);
    checkOutput("done_after_start", int'(done_sel), 0);
  endtask

  task automatic waitRun();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checkOutput("scoreboard_drain", sb.size(), 0);
      sb.delete();
    end
    model_busy = 1'b0;
  endtask

  task automatic resetDut();
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < 16; p++) begin
      ma[p] = '0;
      mb[p] = '0;
    end
    model_busy = 1'b0;
    e.kind  = 1;
    e.n     = cur_n;
    e.issue = cyc;
    e.c     = '0;
    sb.push_back(e);
    waitRun();
  endtask

  task automatic readAll(input exp_t e);
    for (int p = 0; p < e.n * e.n; p++) begin
      for (int b = 0; b < 2; b++) begin
        rd_addr = 4'(p);
        rd_byte = b[0];
        #1;
        checkOutput($sformatf("C%0d_byte%0d", p, b), int'(rd_data_sel), int'(e.c[p][8*b +: 8]));
      end
    end
    if (e.n == 3) begin
      rd_addr = 4'd9;
      rd_byte = 1'b0;
      #1;
      checkOutput("rd_oob_9", int'(rd_data_sel), 0);
      rd_addr = 4'd15;
      #1;
      checkOutput("rd_oob_15", int'(rd_data_sel), 0);
    end
  endtask

  // Monitor: pops the oldest expectation when done rises (or at once after a reset).
  initial begin : monitor
    exp_t e;
    bit   prev_done;
    int   age;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb[0];
        age = cyc - e.issue;
        if (e.kind == 1) begin
          checkOutput("rst_busy", int'(busy_sel), 0);
          checkOutput("rst_done", int'(done_sel), 0);
          readAll(e);
          void'(sb.pop_front());
        end else if (done_sel && !prev_done) begin
          checkOutput("latency", age, 3 * e.n + 1);
          checkOutput("busy_in_done", int'(busy_sel), 0);
          readAll(e);
          void'(sb.pop_front());
        end else if (age > 3 * e.n + 8) begin
          checkOutput("done_timeout", age, 3 * e.n + 1);
          void'(sb.pop_front());
        end else if (age >= 1 && age <= 3 * e.n) begin
          checkOutput("busy_run", int'(busy_sel), 1);
        end
      end
      prev_done = done_sel;
    end
  end

  initial begin : stim
    logic [7:0] a20[4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] b20[4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    repeat (2) @(posedge clk);
    resetDut();

    signed_mode = 1'b0;
    for (int p = 0; p < 4; p++) begin
      loadElem(1'b0, p, a20[p]);
      loadElem(1'b1, p, b20[p]);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();

    for (int p = 0; p < 4; p++) begin
      loadElem(1'b0, p, 8'hFF);
      loadElem(1'b1, p, 8'h02);
    end
    signed_mode = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();
    signed_mode = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();

    for (int p = 0; p < 4; p++) loadElem(1'b1, p, 8'hFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();

    // A start pulse two cycles into a run must not disturb it.
    for (int p = 0; p < 4; p++) begin
      loadElem(1'b0, p, a20[p]);
      loadElem(1'b1, p, b20[p]);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitRun();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();

    applyStimulus(1'b1, 1'b1, 1'b0, 3, 8'h0A);
    waitRun();

    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 4; p++) begin
        loadElem(1'b0, p, 8'($urandom));
        loadElem(1'b1, p, 8'($urandom));
      end
      signed_mode = 1'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
      if (r % 2 == 1) loadElem(1'b1, r % 4, 8'($urandom));
      waitRun();
    end

    // Reset three cycles into a run, then rerun without reloading.
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();

    cur_n = 3;
    resetDut();
    signed_mode = 1'b0;
    for (int p = 0; p < 9; p++) begin
      loadElem(1'b0, p, (p % 4 == 0) ? 8'd1 : 8'd0);
      loadElem(1'b1, p, 8'(p + 1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    loadElem(1'b0, 0, 8'd7);
    waitRun();
    loadElem(1'b0, 12, 8'h55);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
    waitRun();

    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 9; p++) begin
        loadElem(1'b0, p, 8'($urandom));
        loadElem(1'b1, p, 8'($urandom));
      end
      signed_mode = 1'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
      waitRun();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
